// File: rtl/sound_scheduler_pkg.sv
// Shared definitions for the sound scheduler: source indices, FSM states,
// default timing constants and the fixed-priority source picker.
package sound_scheduler_pkg;

    localparam int NUM_SRC  = 3;
    localparam int SRC_HIT  = 0;
    localparam int SRC_WALL = 1;
    localparam int SRC_GOAL = 2;

    localparam int DEF_CNT_W    = 26;
    localparam int DEF_HIT_DUR  = 10_000_000;
    localparam int DEF_WALL_DUR = 5_000_000;
    localparam int DEF_GOAL_DUR = 50_000_000;
    localparam int DEF_GAP_CYC  = 1_000_000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PLAY = 2'd1,
        ST_GAP  = 2'd2
    } state_e;

    // One-hot grant of the highest-priority pending source: goal > hit > wall
    function automatic logic [NUM_SRC-1:0] pickSource(input logic [NUM_SRC-1:0] pend);
        logic [NUM_SRC-1:0] grant;
        grant = '0;
        if (pend[SRC_GOAL]) begin
            grant[SRC_GOAL] = 1'b1;
        end else if (pend[SRC_HIT]) begin
            grant[SRC_HIT] = 1'b1;
        end else if (pend[SRC_WALL]) begin
            grant[SRC_WALL] = 1'b1;
        end
        return grant;
    endfunction

endpackage

// File: rtl/sound_scheduler_event_latch.sv
// Rising-edge detector plus sticky pending flag for one sound source.
// Repeated events before the flag is cleared collapse into a single request.
module sound_scheduler_event_latch (
    input  logic clk,
    input  logic rst,
    input  logic in,
    input  logic clr,
    output logic pend
);

    logic prev_q;
    logic pend_q;
    logic pend_d;
    logic risingEdge;

    assign risingEdge = in & ~prev_q;

    // A fresh edge outranks a same-cycle clear, so an event landing on its own grant replays later
    always_comb begin
        pend_d = pend_q;
        if (risingEdge) begin
            pend_d = 1'b1;
        end else if (clr) begin
            pend_d = 1'b0;
        end
    end

    // History resets high so a level already asserted at reset release is not taken as an event
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prev_q <= 1'b1;
            pend_q <= 1'b0;
        end else begin
            prev_q <= in;
            pend_q <= pend_d;
        end
    end

    assign pend = pend_q;

endmodule

// File: rtl/sound_scheduler.sv
// Arbitrates the single speaker path between hit, wall and goal sounds.
// One sound plays at a time for its programmed length, optionally followed by
// silence; a pending goal cuts short a hit or wall sound.
module sound_scheduler
    import sound_scheduler_pkg::*;
#(
    parameter int CNT_W    = DEF_CNT_W,
    parameter int HIT_DUR  = DEF_HIT_DUR,
    parameter int WALL_DUR = DEF_WALL_DUR,
    parameter int GOAL_DUR = DEF_GOAL_DUR,
    parameter int GAP_CYC  = DEF_GAP_CYC
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       hit,
    input  logic       wall,
    input  logic       goal,
    output logic [2:0] snd_sel,
    output logic       snd_start,
    output logic       busy,
    output logic       drop
);

    localparam logic [CNT_W-1:0] HIT_LOAD  = CNT_W'(HIT_DUR - 1);
    localparam logic [CNT_W-1:0] WALL_LOAD = CNT_W'(WALL_DUR - 1);
    localparam logic [CNT_W-1:0] GOAL_LOAD = CNT_W'(GOAL_DUR - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD  = (GAP_CYC > 0) ? CNT_W'(GAP_CYC - 1) : '0;
    localparam logic [NUM_SRC-1:0] GOAL_SEL = NUM_SRC'(1 << SRC_GOAL);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [NUM_SRC-1:0] sel_q, sel_d;
    logic               start_q, start_d;
    logic               drop_q, drop_d;

    logic [NUM_SRC-1:0] eventIn;
    logic [NUM_SRC-1:0] pendVec;
    logic [NUM_SRC-1:0] clrVec;
    logic [NUM_SRC-1:0] grantVec;

    assign eventIn  = {goal, wall, hit};
    assign grantVec = pickSource(pendVec);

    for (genvar i = 0; i < NUM_SRC; i++) begin : gLatch
        sound_scheduler_event_latch uLatch (
            .clk  (clk),
            .rst  (rst),
            .in   (eventIn[i]),
            .clr  (clrVec[i]),
            .pend (pendVec[i])
        );
    end

    function automatic logic [CNT_W-1:0] loadFor(input logic [NUM_SRC-1:0] grant);
        if (grant[SRC_GOAL]) begin
            return GOAL_LOAD;
        end else if (grant[SRC_HIT]) begin
            return HIT_LOAD;
        end
        return WALL_LOAD;
    endfunction

    // Next-state logic: grant from IDLE, goal preemption and countdown in PLAY, silence in GAP
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sel_d   = sel_q;
        start_d = 1'b0;
        drop_d  = 1'b0;
        clrVec  = '0;
        case (state_q)
            ST_IDLE: begin
                if (|pendVec) begin
                    state_d = ST_PLAY;
                    sel_d   = grantVec;
                    clrVec  = grantVec;
                    cnt_d   = loadFor(grantVec);
                    start_d = 1'b1;
                end
            end
            ST_PLAY: begin
                if (!sel_q[SRC_GOAL] && pendVec[SRC_GOAL]) begin
                    sel_d            = GOAL_SEL;
                    clrVec[SRC_GOAL] = 1'b1;
                    cnt_d            = GOAL_LOAD;
                    start_d          = 1'b1;
                    drop_d           = 1'b1;
                end else if (cnt_q == '0) begin
                    if (GAP_CYC > 0) begin
                        state_d = ST_GAP;
                        cnt_d   = GAP_LOAD;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_GAP: begin
                if (cnt_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // State, shared counter, granted source and the registered one-cycle pulses
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            sel_q   <= '0;
            start_q <= 1'b0;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sel_q   <= sel_d;
            start_q <= start_d;
            drop_q  <= drop_d;
        end
    end

    assign snd_sel   = (state_q == ST_PLAY) ? sel_q : '0;
    assign busy      = (state_q != ST_IDLE);
    assign snd_start = start_q;
    assign drop      = drop_q;

endmodule

// File: tb/tb_sound_scheduler.sv
// Bench for sound_scheduler: two instances (with and without a silence gap)
// share random and directed event stimulus; a per-source timeline model
// predicts every grant and the per-cycle speaker/busy outputs.
module tb_sound_scheduler;

    localparam int CW  = 4;
    localparam int HD  = 4;
    localparam int WD  = 3;
    localparam int GD  = 6;
    localparam int GAP = 2;

    localparam int IDX_HIT  = 0;
    localparam int IDX_WALL = 1;
    localparam int IDX_GOAL = 2;

    typedef struct {
        int         cyc;
        logic [2:0] sel;
        logic       drop;
    } startRec_t;

    logic       clk;
    logic       rst;
    logic       hit;
    logic       wall;
    logic       goal;
    logic [2:0] sndSel   [2];
    logic       sndStart [2];
    logic       busyO    [2];
    logic       dropO    [2];

    int durOf [3] = '{HD, WD, GD};
    int gapOf [2] = '{GAP, 0};

    int         mCur  [2];
    int         mPlay [2];
    int         mGap  [2];
    bit         mPend [2][3];
    bit         mPrev [3];
    logic [2:0] expSel   [2];
    logic       expBusy  [2];
    logic       expDrop  [2];
    int         cycleCount;
    startRec_t  startQ0 [$];
    startRec_t  startQ1 [$];

    int compared;
    int mismatched;

    sound_scheduler #(
        .CNT_W    (CW),
        .HIT_DUR  (HD),
        .WALL_DUR (WD),
        .GOAL_DUR (GD),
        .GAP_CYC  (GAP)
    ) dutGap (
        .clk       (clk),
        .rst       (rst),
        .hit       (hit),
        .wall      (wall),
        .goal      (goal),
        .snd_sel   (sndSel[0]),
        .snd_start (sndStart[0]),
        .busy      (busyO[0]),
        .drop      (dropO[0])
    );

    sound_scheduler #(
        .CNT_W    (CW),
        .HIT_DUR  (HD),
        .WALL_DUR (WD),
        .GOAL_DUR (GD),
        .GAP_CYC  (0)
    ) dutNoGap (
        .clk       (clk),
        .rst       (rst),
        .hit       (hit),
        .wall      (wall),
        .goal      (goal),
        .snd_sel   (sndSel[1]),
        .snd_start (sndStart[1]),
        .busy      (busyO[1]),
        .drop      (dropO[1])
    );

    // Free-running clock, 10 time units per cycle
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input int inst,
                               input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s dut%0d: got %0h expected %0h at cycle %0d",
                     name, inst, act, exp, cycleCount);
        end
    endtask

    task automatic modelReset();
        for (int k = 0; k < 2; k++) begin
            mCur[k]    = -1;
            mPlay[k]   = 0;
            mGap[k]    = 0;
            expSel[k]  = 3'b000;
            expBusy[k] = 1'b0;
            expDrop[k] = 1'b0;
            for (int i = 0; i < 3; i++) mPend[k][i] = 1'b0;
        end
        for (int i = 0; i < 3; i++) mPrev[i] = 1'b1;
        startQ0.delete();
        startQ1.delete();
    endtask

    task automatic modelGrant(input int k, input int src, input bit isDrop);
        startRec_t rec;
        mCur[k]       = src;
        mPlay[k]      = durOf[src];
        mPend[k][src] = 1'b0;
        expDrop[k]    = isDrop;
        rec.cyc  = cycleCount;
        rec.sel  = 3'(1 << src);
        rec.drop = isDrop;
        if (k == 0) startQ0.push_back(rec);
        else        startQ1.push_back(rec);
    endtask

    // Timeline model: a sound owns the speaker for durOf cycles, then gapOf silent cycles, then one idle cycle
    task automatic modelStep();
        bit inNow   [3];
        bit edgeNow [3];
        int best;
        inNow[IDX_HIT]  = hit;
        inNow[IDX_WALL] = wall;
        inNow[IDX_GOAL] = goal;
        cycleCount++;
        for (int i = 0; i < 3; i++) edgeNow[i] = inNow[i] && !mPrev[i];
        for (int k = 0; k < 2; k++) begin
            expDrop[k] = 1'b0;
            if (mCur[k] >= 0) begin
                if (mCur[k] != IDX_GOAL && mPend[k][IDX_GOAL]) begin
                    modelGrant(k, IDX_GOAL, 1'b1);
                end else begin
                    mPlay[k]--;
                    if (mPlay[k] == 0) begin
                        mCur[k] = -1;
                        mGap[k] = gapOf[k];
                    end
                end
            end else if (mGap[k] > 0) begin
                mGap[k]--;
            end else begin
                best = -1;
                if (mPend[k][IDX_GOAL])      best = IDX_GOAL;
                else if (mPend[k][IDX_HIT])  best = IDX_HIT;
                else if (mPend[k][IDX_WALL]) best = IDX_WALL;
                if (best >= 0) modelGrant(k, best, 1'b0);
            end
            for (int i = 0; i < 3; i++) begin
                if (edgeNow[i]) mPend[k][i] = 1'b1;
            end
            expSel[k]  = (mCur[k] >= 0) ? 3'(1 << mCur[k]) : 3'b000;
            expBusy[k] = (mCur[k] >= 0) || (mGap[k] > 0);
        end
        for (int i = 0; i < 3; i++) mPrev[i] = inNow[i];
    endtask

    // Reference model follows the same clock and asynchronous reset as the designs
    always @(posedge clk or negedge rst) begin
        if (!rst) modelReset();
        else      modelStep();
    end

    task automatic monitorOne(input int k);
        startRec_t rec;
        bit        have;
        bit        expNow;
        checkOutput("snd_sel", k, 32'(sndSel[k]), 32'(expSel[k]));
        checkOutput("busy",    k, 32'(busyO[k]),  32'(expBusy[k]));
        checkOutput("drop",    k, 32'(dropO[k]),  32'(expDrop[k]));
        if (k == 0) have = (startQ0.size() > 0) && (startQ0[0].cyc <= cycleCount);
        else        have = (startQ1.size() > 0) && (startQ1[0].cyc <= cycleCount);
        expNow = have;
        checkOutput("snd_start", k, 32'(sndStart[k]), 32'(expNow));
        if (expNow) begin
            if (k == 0) rec = startQ0.pop_front();
            else        rec = startQ1.pop_front();
            if (sndStart[k]) begin
                checkOutput("grant cycle", k, 32'(cycleCount), 32'(rec.cyc));
                checkOutput("grant sel",   k, 32'(sndSel[k]),  32'(rec.sel));
                checkOutput("grant drop",  k, 32'(dropO[k]),   32'(rec.drop));
            end
        end
    endtask

    // Monitor samples both designs mid-cycle and retires expected grants from the scoreboard
    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) monitorOne(k);
    end

    task automatic waitCycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic h, input logic w, input logic g);
        hit  = h;
        wall = w;
        goal = g;
    endtask

    task automatic pulse(input logic h, input logic w, input logic g);
        applyStimulus(h, w, g);
        waitCycles(1);
        applyStimulus(1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        cycleCount = 0;
        clk        = 1'b0;
        rst        = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b0);
        modelReset();
        waitCycles(3);
        rst = 1'b1;
        waitCycles(2);

        $display("[TB] single hit");
        pulse(1'b1, 1'b0, 1'b0);
        waitCycles(12);

        $display("[TB] hit, wall and goal together");
        pulse(1'b1, 1'b1, 1'b1);
        waitCycles(30);

        $display("[TB] goal preempts hit");
        pulse(1'b1, 1'b0, 1'b0);
        waitCycles(3);
        pulse(1'b0, 1'b0, 1'b1);
        waitCycles(20);

        $display("[TB] hit retriggered while playing");
        pulse(1'b1, 1'b0, 1'b0);
        waitCycles(2);
        for (int p = 0; p < 3; p++) begin
            pulse(1'b1, 1'b0, 1'b0);
            waitCycles(1);
        end
        waitCycles(20);

        $display("[TB] reset mid-play with goal held");
        pulse(1'b1, 1'b0, 1'b0);
        waitCycles(2);
        goal = 1'b1;
        #2;
        rst = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) begin
            checkOutput("async reset snd_sel",   k, 32'(sndSel[k]),   32'd0);
            checkOutput("async reset busy",      k, 32'(busyO[k]),    32'd0);
            checkOutput("async reset snd_start", k, 32'(sndStart[k]), 32'd0);
            checkOutput("async reset drop",      k, 32'(dropO[k]),    32'd0);
        end
        waitCycles(2);
        rst = 1'b1;
        waitCycles(10);
        goal = 1'b0;
        waitCycles(10);

        $display("[TB] wall then hit queued");
        pulse(1'b0, 1'b1, 1'b0);
        pulse(1'b1, 1'b0, 1'b0);
        waitCycles(20);

        $display("[TB] random events");
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 7) == 0) hit  = ~hit;
            if ($urandom_range(0, 9) == 0) wall = ~wall;
            if ($urandom_range(0, 15) == 0) goal = ~goal;
            if ($urandom_range(0, 599) == 0) begin
                #2;
                rst = 1'b0;
                waitCycles(2);
                rst = 1'b1;
            end
            waitCycles(1);
        end
        applyStimulus(1'b0, 1'b0, 1'b0);
        waitCycles(40);

        checkOutput("grants outstanding", 0, 32'(startQ0.size()), 32'd0);
        checkOutput("grants outstanding", 1, 32'(startQ1.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
